// File: rtl/simd_instruction_loader.sv
// SIMD instruction loader: writes the instruction stream into IMEM and keeps the group start-address table.
// Optional define SIMD_LOADER_RD_CHECK_EN makes table reads of groups that are not fully loaded return rd_v=0.
module simd_instruction_loader #(
    parameter int OPCODE_BITS       = 4,
    parameter int FUNCTION_BITS     = 4,
    parameter int NS_ID_BITS        = 3,
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int GROUP_ID_W        = 4,
    parameter int MAX_NUM_GROUPS    = 1 << GROUP_ID_W,
    parameter int IMEM_ADDR_WIDTH   = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic [INSTRUCTION_WIDTH-1:0] inst_in,
    input  logic                         inst_in_v,
    output logic                         inst_in_ready,
    output logic                         imem_wr_req,
    output logic [IMEM_ADDR_WIDTH-1:0]   imem_wr_addr,
    output logic [INSTRUCTION_WIDTH-1:0] imem_wr_data,
    input  logic                         group_buf_rd_req,
    input  logic [GROUP_ID_W-1:0]        group_buf_rd_addr,
    output logic [IMEM_ADDR_WIDTH-1:0]   group_buf_rd_data,
    output logic                         group_buf_rd_v,
    output logic [MAX_NUM_GROUPS-1:0]    group_valid,
    output logic                         group_loaded,
    output logic [GROUP_ID_W-1:0]        loaded_group_id,
    output logic [2:0]                   err
);

    localparam int OPC_LSB = INSTRUCTION_WIDTH - OPCODE_BITS;
    localparam int FN_LSB  = OPC_LSB - FUNCTION_BITS;
    localparam int NS_LSB  = FN_LSB - NS_ID_BITS;

    typedef enum logic [1:0] {
        IDLE,
        IN_GROUP,
        FULL
    } state_t;

    state_t                       state_q, state_d;
    logic [IMEM_ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [GROUP_ID_W-1:0]        cur_id_q, cur_id_d;
    logic [MAX_NUM_GROUPS-1:0]    valid_q, valid_d;
    logic [2:0]                   err_q, err_d;
    logic                         loaded_q, loaded_d;
    logic [GROUP_ID_W-1:0]        loaded_id_q, loaded_id_d;
    logic                         wr_req_q;
    logic [IMEM_ADDR_WIDTH-1:0]   wr_addr_q;
    logic [INSTRUCTION_WIDTH-1:0] wr_data_q;
    logic                         rd_v_q;
    logic [IMEM_ADDR_WIDTH-1:0]   rd_data_q;
    logic [IMEM_ADDR_WIDTH-1:0]   grp_tbl_q [MAX_NUM_GROUPS];

    logic                  is_gs, is_ge;
    logic [GROUP_ID_W-1:0] inst_id;
    logic                  wr_en;
    logic                  tbl_we;
    logic [GROUP_ID_W-1:0] tbl_wa;
    logic                  rd_ok;
    logic [IMEM_ADDR_WIDTH-1:0] rd_value;

    assign is_gs   = (inst_in[INSTRUCTION_WIDTH-1:OPC_LSB] == OPCODE_BITS'(10)) &&
                     (inst_in[FN_LSB+3:FN_LSB+2] == 2'b10);
    assign is_ge   = (inst_in[INSTRUCTION_WIDTH-1:OPC_LSB] == OPCODE_BITS'(10)) &&
                     (inst_in[FN_LSB+3:FN_LSB+2] == 2'b11);
    assign inst_id = {inst_in[FN_LSB+1:FN_LSB], inst_in[NS_LSB+2:NS_LSB+1]};

    // A group start always records its address and invalidates the id, whether or not a group was open.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        cur_id_d    = cur_id_q;
        valid_d     = valid_q;
        err_d       = err_q;
        loaded_d    = 1'b0;
        loaded_id_d = loaded_id_q;
        wr_en       = 1'b0;
        tbl_we      = 1'b0;
        tbl_wa      = inst_id;
        if (inst_in_v) begin
            case (state_q)
                IDLE: begin
                    if (is_gs) begin
                        wr_en            = 1'b1;
                        tbl_we           = 1'b1;
                        cur_id_d         = inst_id;
                        valid_d[inst_id] = 1'b0;
                        state_d          = IN_GROUP;
                    end else begin
                        err_d[0] = 1'b1;
                    end
                end
                IN_GROUP: begin
                    wr_en = 1'b1;
                    if (is_gs) begin
                        err_d[1]         = 1'b1;
                        tbl_we           = 1'b1;
                        cur_id_d         = inst_id;
                        valid_d[inst_id] = 1'b0;
                    end else if (is_ge) begin
                        valid_d[cur_id_q] = 1'b1;
                        loaded_d          = 1'b1;
                        loaded_id_d       = cur_id_q;
                        state_d           = IDLE;
                    end
                end
                FULL:    err_d[2] = 1'b1;
                default: ;
            endcase
        end
        if (wr_en) begin
            if (wr_ptr_q == '1) begin
                state_d = FULL;
            end else begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
        end
    end

    // A read of the entry being written this cycle returns the new start address.
    always_comb begin
        rd_value = grp_tbl_q[group_buf_rd_addr];
        if (tbl_we && (tbl_wa == group_buf_rd_addr)) begin
            rd_value = wr_ptr_q;
        end
`ifdef SIMD_LOADER_RD_CHECK_EN
        rd_ok = group_buf_rd_req && valid_d[group_buf_rd_addr];
`else
        rd_ok = group_buf_rd_req;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            cur_id_q    <= '0;
            valid_q     <= '0;
            err_q       <= '0;
            loaded_q    <= 1'b0;
            loaded_id_q <= '0;
            wr_req_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_v_q      <= 1'b0;
            rd_data_q   <= '0;
            for (int i = 0; i < MAX_NUM_GROUPS; i++) begin
                grp_tbl_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            cur_id_q    <= cur_id_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            loaded_q    <= loaded_d;
            loaded_id_q <= loaded_id_d;
            wr_req_q    <= wr_en;
            if (wr_en) begin
                wr_addr_q <= wr_ptr_q;
                wr_data_q <= inst_in;
            end
            if (tbl_we) begin
                grp_tbl_q[tbl_wa] <= wr_ptr_q;
            end
            rd_v_q <= rd_ok;
            if (rd_ok) begin
                rd_data_q <= rd_value;
            end
        end
    end

    assign inst_in_ready     = (state_q != FULL);
    assign imem_wr_req       = wr_req_q;
    assign imem_wr_addr      = wr_addr_q;
    assign imem_wr_data      = wr_data_q;
    assign group_buf_rd_data = rd_data_q;
    assign group_buf_rd_v    = rd_v_q;
    assign group_valid       = valid_q;
    assign group_loaded      = loaded_q;
    assign loaded_group_id   = loaded_id_q;
    assign err               = err_q;

endmodule

// File: tb/tb_simd_instruction_loader.sv
// Testbench for simd_instruction_loader: per-cycle comparison against a behavioural model plus literal checks.
module tb_simd_instruction_loader;

    localparam int DEPTH = 1024;

    logic        clk;
    logic        reset;
    logic        clear;
    logic [31:0] inst_in;
    logic        inst_in_v;
    logic        inst_in_ready;
    logic        imem_wr_req;
    logic [9:0]  imem_wr_addr;
    logic [31:0] imem_wr_data;
    logic        group_buf_rd_req;
    logic [3:0]  group_buf_rd_addr;
    logic [9:0]  group_buf_rd_data;
    logic        group_buf_rd_v;
    logic [15:0] group_valid;
    logic        group_loaded;
    logic [3:0]  loaded_group_id;
    logic [2:0]  err;

    simd_instruction_loader dut (
        .clk               (clk),
        .reset             (reset),
        .clear             (clear),
        .inst_in           (inst_in),
        .inst_in_v         (inst_in_v),
        .inst_in_ready     (inst_in_ready),
        .imem_wr_req       (imem_wr_req),
        .imem_wr_addr      (imem_wr_addr),
        .imem_wr_data      (imem_wr_data),
        .group_buf_rd_req  (group_buf_rd_req),
        .group_buf_rd_addr (group_buf_rd_addr),
        .group_buf_rd_data (group_buf_rd_data),
        .group_buf_rd_v    (group_buf_rd_v),
        .group_valid       (group_valid),
        .group_loaded      (group_loaded),
        .loaded_group_id   (loaded_group_id),
        .err               (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nCompared   = 0;
    int nMismatched = 0;
    bit checkEn     = 1'b0;

    // Model state: what the loader must hold, tracked with plain ints and arrays.
    int          mPtr;
    bit          mInGroup;
    bit          mFull;
    int          mCur;
    int          mTable [16];
    logic [15:0] mValid;
    logic [2:0]  mErr;
    bit          expWrReq;
    int          expWrAddr;
    logic [31:0] expWrData;
    bit          expLoaded;
    int          expLoadedId;
    bit          expRdV;
    int          expRdData;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] mkGS(input logic [3:0] id);
        mkGS = {4'hA, 2'b10, id[3:2], id[1:0], 1'b0, 21'h0_1234};
    endfunction

    function automatic logic [31:0] mkGE(input logic [3:0] id);
        mkGE = {4'hA, 2'b11, id[3:2], id[1:0], 1'b0, 21'h0_0ABC};
    endfunction

    function automatic logic [31:0] mkOp(input int n);
        mkOp = {4'h1, 4'h3, 24'(n)};
    endfunction

    task automatic modelReset();
        mPtr        = 0;
        mInGroup    = 1'b0;
        mFull       = 1'b0;
        mCur        = 0;
        mValid      = '0;
        mErr        = '0;
        expWrReq    = 1'b0;
        expWrAddr   = 0;
        expWrData   = '0;
        expLoaded   = 1'b0;
        expLoadedId = 0;
        expRdV      = 1'b0;
        expRdData   = 0;
        for (int i = 0; i < 16; i++) mTable[i] = 0;
    endtask

    // One clock of the loader's rules: handle the offered word, then the table read (which sees this cycle's write).
    task automatic modelStep();
        bit gs, ge;
        int id;
        expWrReq  = 1'b0;
        expLoaded = 1'b0;
        expRdV    = 1'b0;
        if (reset || clear) begin
            modelReset();
            return;
        end
        gs = (inst_in[31:28] == 4'd10) && (inst_in[27:26] == 2'b10);
        ge = (inst_in[31:28] == 4'd10) && (inst_in[27:26] == 2'b11);
        id = int'({inst_in[25:24], inst_in[23:22]});
        if (inst_in_v) begin
            if (mFull) begin
                mErr[2] = 1'b1;
            end else if (!mInGroup && !gs) begin
                mErr[0] = 1'b1;
            end else begin
                expWrReq  = 1'b1;
                expWrAddr = mPtr;
                expWrData = inst_in;
                if (gs) begin
                    if (mInGroup) mErr[1] = 1'b1;
                    mTable[id] = mPtr;
                    mCur       = id;
                    mValid[id] = 1'b0;
                    mInGroup   = 1'b1;
                end else if (ge) begin
                    mValid[mCur] = 1'b1;
                    expLoaded    = 1'b1;
                    expLoadedId  = mCur;
                    mInGroup     = 1'b0;
                end
                if (mPtr == DEPTH - 1) mFull = 1'b1;
                else mPtr = mPtr + 1;
            end
        end
        if (group_buf_rd_req) begin
`ifdef SIMD_LOADER_RD_CHECK_EN
            expRdV = mValid[group_buf_rd_addr];
`else
            expRdV = 1'b1;
`endif
            if (expRdV) expRdData = mTable[group_buf_rd_addr];
        end
    endtask

    initial begin
        modelReset();
        forever begin
            @(posedge clk);
            modelStep();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (checkEn) begin
                checkOutput("inst_in_ready", 32'(inst_in_ready), 32'(!mFull));
                checkOutput("imem_wr_req", 32'(imem_wr_req), 32'(expWrReq));
                if (expWrReq) begin
                    checkOutput("imem_wr_addr", 32'(imem_wr_addr), 32'(expWrAddr));
                    checkOutput("imem_wr_data", imem_wr_data, expWrData);
                end
                checkOutput("group_valid", 32'(group_valid), 32'(mValid));
                checkOutput("group_loaded", 32'(group_loaded), 32'(expLoaded));
                checkOutput("loaded_group_id", 32'(loaded_group_id), 32'(expLoadedId));
                checkOutput("err", 32'(err), 32'(mErr));
                checkOutput("rd_v", 32'(group_buf_rd_v), 32'(expRdV));
                if (expRdV) checkOutput("rd_data", 32'(group_buf_rd_data), 32'(expRdData));
            end
        end
    end

    // Drives one cycle of inputs starting at a falling edge; outputs are settled at the next falling edge.
    task automatic applyStimulus(input bit v, input logic [31:0] w, input bit rq, input logic [3:0] ra);
        inst_in           = w;
        inst_in_v         = v;
        group_buf_rd_req  = rq;
        group_buf_rd_addr = ra;
        @(negedge clk);
        inst_in_v        = 1'b0;
        group_buf_rd_req = 1'b0;
    endtask

    task automatic doClear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset             = 1'b1;
        clear             = 1'b0;
        inst_in           = '0;
        inst_in_v         = 1'b0;
        group_buf_rd_req  = 1'b0;
        group_buf_rd_addr = '0;
        repeat (2) @(negedge clk);
        reset   = 1'b0;
        checkEn = 1'b1;
        checkOutput("reset ready", 32'(inst_in_ready), 32'd1);
        checkOutput("reset err", 32'(err), 32'd0);
        checkOutput("reset group_valid", 32'(group_valid), 32'd0);
        checkOutput("reset wr_req", 32'(imem_wr_req), 32'd0);
        checkOutput("reset rd_v", 32'(group_buf_rd_v), 32'd0);

        // Group 3: GS, four ops, GE at addresses 0..5
        applyStimulus(1'b1, mkGS(4'd3), 1'b0, 4'd0);
        checkOutput("gs3 addr", 32'(imem_wr_addr), 32'd0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, mkOp(i), 1'b0, 4'd0);
        applyStimulus(1'b1, mkGE(4'd3), 1'b0, 4'd0);
        checkOutput("ge3 addr", 32'(imem_wr_addr), 32'd5);
        checkOutput("ge3 loaded", 32'(group_loaded), 32'd1);
        checkOutput("ge3 id", 32'(loaded_group_id), 32'd3);
        checkOutput("ge3 valid", 32'(group_valid), 32'h0008);

        // Group 7 at 6..9, then back-to-back reads of 7 and 3
        applyStimulus(1'b1, mkGS(4'd7), 1'b0, 4'd0);
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, mkOp(10 + i), 1'b0, 4'd0);
        applyStimulus(1'b1, mkGE(4'd7), 1'b0, 4'd0);
        applyStimulus(1'b0, '0, 1'b1, 4'd7);
        checkOutput("rd7 v", 32'(group_buf_rd_v), 32'd1);
        checkOutput("rd7 data", 32'(group_buf_rd_data), 32'd6);
        applyStimulus(1'b0, '0, 1'b1, 4'd3);
        checkOutput("rd3 data", 32'(group_buf_rd_data), 32'd0);
        applyStimulus(1'b0, '0, 1'b0, 4'd0);
        checkOutput("rd idle v", 32'(group_buf_rd_v), 32'd0);

        // Orphan word in IDLE, then a normal group 4
        doClear();
        applyStimulus(1'b1, mkOp(99), 1'b0, 4'd0);
        checkOutput("orphan wr_req", 32'(imem_wr_req), 32'd0);
        checkOutput("orphan err", 32'(err), 32'b001);
        applyStimulus(1'b1, mkGS(4'd4), 1'b0, 4'd0);
        checkOutput("gs4 addr", 32'(imem_wr_addr), 32'd0);
        applyStimulus(1'b1, mkOp(5), 1'b0, 4'd0);
        applyStimulus(1'b1, mkGE(4'd4), 1'b0, 4'd0);
        checkOutput("ge4 valid", 32'(group_valid), 32'h0010);

        // Nested start: group 1 abandoned, group 2 completes at table entry 2
        doClear();
        applyStimulus(1'b1, mkGS(4'd1), 1'b0, 4'd0);
        applyStimulus(1'b1, mkOp(1), 1'b0, 4'd0);
        applyStimulus(1'b1, mkGS(4'd2), 1'b0, 4'd0);
        checkOutput("nested err", 32'(err), 32'b010);
        applyStimulus(1'b1, mkGE(4'd2), 1'b0, 4'd0);
        checkOutput("nested valid", 32'(group_valid), 32'h0004);
        applyStimulus(1'b0, '0, 1'b1, 4'd2);
        checkOutput("rd2 data", 32'(group_buf_rd_data), 32'd2);

        // Never-loaded group 5, then a same-cycle start and read of 5
        applyStimulus(1'b0, '0, 1'b1, 4'd5);
`ifdef SIMD_LOADER_RD_CHECK_EN
        checkOutput("rd5 v", 32'(group_buf_rd_v), 32'd0);
`else
        checkOutput("rd5 v", 32'(group_buf_rd_v), 32'd1);
        checkOutput("rd5 data", 32'(group_buf_rd_data), 32'd0);
`endif
        applyStimulus(1'b1, mkGS(4'd5), 1'b1, 4'd5);
        checkOutput("gs5 addr", 32'(imem_wr_addr), 32'd4);
`ifndef SIMD_LOADER_RD_CHECK_EN
        checkOutput("bypass data", 32'(group_buf_rd_data), 32'd4);
`endif
        applyStimulus(1'b1, mkGE(4'd5), 1'b0, 4'd0);

        // Fill all of IMEM with one group whose GE lands in the last slot
        doClear();
        applyStimulus(1'b1, mkGS(4'd0), 1'b0, 4'd0);
        for (int i = 0; i < DEPTH - 2; i++) applyStimulus(1'b1, mkOp(i), 1'b0, 4'd0);
        checkOutput("pre-full ready", 32'(inst_in_ready), 32'd1);
        applyStimulus(1'b1, mkGE(4'd0), 1'b0, 4'd0);
        checkOutput("full addr", 32'(imem_wr_addr), 32'd1023);
        checkOutput("full ready", 32'(inst_in_ready), 32'd0);
        checkOutput("full loaded", 32'(group_loaded), 32'd1);
        applyStimulus(1'b1, mkGS(4'd9), 1'b0, 4'd0);
        checkOutput("overflow err", 32'(err), 32'b100);
        checkOutput("overflow wr_req", 32'(imem_wr_req), 32'd0);
        doClear();
        checkOutput("clear ready", 32'(inst_in_ready), 32'd1);
        applyStimulus(1'b1, mkGS(4'd6), 1'b0, 4'd0);
        checkOutput("after clear addr", 32'(imem_wr_addr), 32'd0);
        applyStimulus(1'b1, mkGE(4'd6), 1'b0, 4'd0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
